// File: rtl/scope_capture.sv
`default_nettype none
// scope_capture: level-triggered capture of the audio stream into the time-domain display memory.
// Optional macro SCOPE_AUTOTRIG_EN forces a trigger after cstAutoTmo strobes without a crossing.
module scope_capture #(
  parameter int cstHorSize = 640,
  parameter int cstDecim   = 1,
  parameter int cstHoldoff = 4800,
  parameter int cstAutoTmo = 9600
) (
  input  logic        ck100MHz,
  input  logic        rst,
  input  logic        run,
  input  logic        sample_valid,
  input  logic [11:0] sample_in,
  input  logic [7:0]  trig_level,
  output logic        enaTime,
  output logic        weaTime,
  output logic [9:0]  addraTime,
  output logic [7:0]  dinaTime,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [9:0]  LAST_ADDR = 10'(cstHorSize - 1);
  localparam logic [7:0]  DEC_LAST  = 8'(cstDecim - 1);
  localparam logic [15:0] HOLD_INIT = 16'(cstHoldoff);

  if (cstHorSize < 2 || cstHorSize > 1024 || cstDecim < 1 || cstDecim > 255 ||
      cstHoldoff < 1 || cstHoldoff > 65535 || cstAutoTmo < 1 || cstAutoTmo > 65536) begin : g_bad_params
    $error("scope_capture: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_HOLDOFF   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cur, prev;
  logic [9:0]  wr_ptr, wr_addr;
  logic [7:0]  dec_cnt;
  logic [15:0] hold_cnt;
  logic        level_hit, trig, dec_hit, last_wr, hold_end;
  logic        wr_go, fd_go;
  logic        unused_lsbs;

  // Offset binary: flip the sign bit and keep the top eight bits.
  assign cur         = {~sample_in[11], sample_in[10:4]};
  assign unused_lsbs = ^sample_in[3:0];

  assign level_hit = sample_valid && (prev < trig_level) && (cur >= trig_level);
  assign dec_hit   = sample_valid && (dec_cnt == DEC_LAST);
  assign last_wr   = dec_hit && (wr_ptr == LAST_ADDR);
  assign hold_end  = sample_valid && (hold_cnt == 16'd1);

`ifdef SCOPE_AUTOTRIG_EN
  localparam logic [15:0] TMO_LAST = 16'(cstAutoTmo - 1);
  logic [15:0] tmo_cnt;

  // Cleared whenever not armed, so it restarts on every entry to WAIT_TRIG.
  always_ff @(posedge ck100MHz) begin
    if (rst || state != S_WAIT_TRIG) tmo_cnt <= '0;
    else if (sample_valid)            tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign trig = level_hit || (sample_valid && tmo_cnt == TMO_LAST);
`else
  assign trig = level_hit;
`endif

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    wr_addr   = wr_ptr;
    fd_go     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_nxt = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end else if (trig) begin
          state_nxt = S_CAPTURE;
          wr_go     = 1'b1;
          wr_addr   = 10'd0;
        end
      end
      S_CAPTURE: begin
        wr_go = dec_hit;
        fd_go = last_wr;
        if (last_wr) state_nxt = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_end) state_nxt = run ? S_WAIT_TRIG : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck100MHz) begin
    if (rst) begin
      state      <= S_IDLE;
      prev       <= 8'h00;
      wr_ptr     <= '0;
      dec_cnt    <= '0;
      hold_cnt   <= '0;
      weaTime    <= 1'b0;
      frame_done <= 1'b0;
      addraTime  <= '0;
      dinaTime   <= '0;
    end else begin
      state      <= state_nxt;
      weaTime    <= wr_go;
      frame_done <= fd_go;
      if (wr_go) begin
        addraTime <= wr_addr;
        dinaTime  <= cur;
      end
      if (sample_valid && state != S_IDLE) prev <= cur;

      case (state)
        S_WAIT_TRIG: begin
          if (wr_go) begin
            wr_ptr  <= 10'd1;
            dec_cnt <= '0;
          end
        end
        S_CAPTURE: begin
          if (dec_hit) begin
            dec_cnt <= '0;
            wr_ptr  <= last_wr ? 10'd0 : wr_ptr + 10'd1;
          end else if (sample_valid) begin
            dec_cnt <= dec_cnt + 8'd1;
          end
          if (last_wr) hold_cnt <= HOLD_INIT;
        end
        S_HOLDOFF: begin
          if (sample_valid) hold_cnt <= hold_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign enaTime = weaTime;
  assign busy    = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scope_capture.sv
`default_nettype none
// tb_scope_capture: directed and random stimulus checked against a strobe-level reference model.
module tb_scope_capture;

  localparam int H    = 32;
  localparam int D    = 3;
  localparam int HOLD = 25;
  localparam int AUTO = 100;

  logic        clk = 1'b0;
  logic        rst, run, sample_valid;
  logic [11:0] sample_in;
  logic [7:0]  trig_level;
  logic        enaTime, weaTime, busy, frame_done;
  logic [9:0]  addraTime;
  logic [7:0]  dinaTime;

  always #5 clk = ~clk;

  scope_capture #(
    .cstHorSize(H), .cstDecim(D), .cstHoldoff(HOLD), .cstAutoTmo(AUTO)
  ) dut (
    .ck100MHz(clk), .rst(rst), .run(run), .sample_valid(sample_valid),
    .sample_in(sample_in), .trig_level(trig_level), .enaTime(enaTime),
    .weaTime(weaTime), .addraTime(addraTime), .dinaTime(dinaTime),
    .busy(busy), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 holding off.
  int m_mode = 0, m_prev = 0, m_n = 0, m_hold = 0, m_tmo = 0;
  int e_addr = 0, e_data = 0;
  bit e_wea = 0, e_fd = 0;
  int m_writes = 0, m_frames = 0;
  int dut_writes = 0, dut_frames = 0;
  int ramp = -2048;

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    checks++;
    assert (obs === 16'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check outputs 1 ns after the edge.
  task automatic cyc(input bit r, input bit rn, input bit v, input int s, input int lvl);
    int cur;
    int old;
    bit hit;
    rst = r; run = rn; sample_valid = v; sample_in = 12'(s); trig_level = 8'(lvl);
    cur   = (s + 2048) / 16;
    e_wea = 0;
    e_fd  = 0;
    old   = m_mode;
    if (r) begin
      m_mode = 0; m_prev = 0; m_n = 0; m_hold = 0; m_tmo = 0; e_addr = 0; e_data = 0;
    end else begin
      case (m_mode)
        0: if (rn) begin m_mode = 1; m_tmo = 0; end
        1: begin
          if (!rn) m_mode = 0;
          else if (v) begin
            hit = (m_prev < lvl) && (cur >= lvl);
`ifdef SCOPE_AUTOTRIG_EN
            if (m_tmo == AUTO - 1) hit = 1;
            m_tmo++;
`endif
            if (hit) begin
              e_wea = 1; e_addr = 0; e_data = cur; m_n = 0; m_mode = 2;
            end
          end
        end
        2: if (v) begin
          m_n++;
          if (m_n % D == 0) begin
            e_wea = 1; e_addr = m_n / D; e_data = cur;
            if (e_addr == H - 1) begin e_fd = 1; m_hold = HOLD; m_mode = 3; end
          end
        end
        default: if (v) begin
          m_hold--;
          if (m_hold == 0) begin m_mode = rn ? 1 : 0; m_tmo = 0; end
        end
      endcase
      if (old != 0 && v) m_prev = cur;
    end
    if (e_wea) m_writes++;
    if (e_fd)  m_frames++;
    @(posedge clk);
    #1;
    chk("wea",        16'(weaTime),    int'(e_wea));
    chk("ena",        16'(enaTime),    int'(e_wea));
    chk("addr",       16'(addraTime),  e_addr);
    chk("data",       16'(dinaTime),   e_data);
    chk("busy",       16'(busy),       int'(m_mode != 0));
    chk("frame_done", 16'(frame_done), int'(e_fd));
    if (weaTime === 1'b1)    dut_writes++;
    if (frame_done === 1'b1) dut_frames++;
  endtask

  function automatic int next_ramp();
    int v;
    v    = ramp;
    ramp = (ramp == 2032) ? -2048 : ramp + 16;
    return v;
  endfunction

  initial begin
    int w0;
    int lvl;
    bit rn;

    // Reset and idle: nothing may be written while run is low.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 128);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, int'($urandom_range(4095)) - 2048, 128);
    chk("idle_writes", 16'(dut_writes), 0);

    // Ramp with sparse random strobes, trigger at zero crossing.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(1) == 1) cyc(0, 1, 1, next_ramp(), 128);
      else                        cyc(0, 1, 0, ramp, 128);
    end
    chk("ramp_frames", 16'(dut_frames), m_frames);

    // Back-to-back strobes.
    for (int i = 0; i < 600; i++) cyc(0, 1, 1, next_ramp(), 128);
    chk("b2b_writes", 16'(dut_writes), m_writes);

    // Random samples, levels, run toggles and occasional resets.
    lvl = 128;
    rn  = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) lvl = int'($urandom_range(255));
      if ($urandom_range(149) == 0) rn = ~rn;
      cyc($urandom_range(599) == 0, rn, $urandom_range(1) == 1,
          int'($urandom_range(4095)) - 2048, lvl);
    end
    chk("rand_frames", 16'(dut_frames), m_frames);

    // Drop run mid-capture: frame and holdoff complete, then park in idle.
    cyc(1, 0, 0, 0, 128);
    ramp = -2048;
    for (int i = 0; i < 2000 && !(m_mode == 2 && m_n / D >= H / 2); i++)
      cyc(0, 1, 1, next_ramp(), 128);
    for (int i = 0; i < 2000 && m_mode != 0; i++) cyc(0, 0, 1, next_ramp(), 128);
    chk("drop_busy", 16'(busy), 0);
    w0 = dut_writes;
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, next_ramp(), 128);
    chk("drop_no_writes", 16'(dut_writes - w0), 0);

    // Constant zero input under a high level: only a forced trigger can fire.
    cyc(1, 0, 0, 0, 200);
    w0 = m_writes;
    for (int i = 0; i < 400; i++) cyc(0, 1, 1, 0, 200);
    chk("auto_writes", 16'(dut_writes), m_writes);
`ifdef SCOPE_AUTOTRIG_EN
    chk("auto_fired", 16'(m_writes > w0), 1);
`else
    chk("no_auto", 16'(m_writes - w0), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scope_capture.md
# scope_capture

Triggered capture engine that fills the time-domain display memory of the image controller. Consumes the 96 kHz audio sample stream, converts each sample to 8-bit offset binary, and waits for a rising crossing of a programmable level. It then writes one screen-width frame of samples through the controller's time-domain write port and holds off before re-arming. Runs entirely in the 100 MHz system domain; the display memory's dual port handles the crossing to the video clock.

## Interface
Parameters:
- cstHorSize, 640: samples per frame; must be 2..1024.
- cstDecim, 1: keep one of every cstDecim accepted samples during capture; must be 1..255.
- cstHoldoff, 4800: sample strobes spent in HOLDOFF after a frame (50 ms at 96 kHz); must be 1..65535.
- cstAutoTmo, 9600: sample strobes without a trigger before a forced trigger. Used only with SCOPE_AUTOTRIG_EN.

Ports:
- ck100MHz, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- run, input, 1: 1 = free-running capture; 0 = finish the current frame, then park in IDLE.
- sample_valid, input, 1: one-cycle strobe per new sample; may assert on consecutive cycles.
- sample_in, input, 12: two's-complement audio sample, valid with sample_valid.
- trig_level, input, 8: trigger threshold in offset binary; 128 = zero.
- enaTime, output, 1: memory port enable; identical to weaTime.
- weaTime, output, 1: one-cycle write strobe.
- addraTime, output, 10: write address, 0..cstHorSize-1.
- dinaTime, output, 8: offset-binary sample.
- busy, output, 1: high in WAIT_TRIG, CAPTURE and HOLDOFF.
- frame_done, output, 1: one-cycle pulse concurrent with the last write of a frame.

## Operation
- Conversion: cur = {~sample_in[11], sample_in[10:4]}, computed combinationally. This maps -2048 to 0, 0 to 128, and +2047 to 255.
- prev register: loads cur on every sample_valid in every state except IDLE. Resets to 8'h00.
- Trigger condition: prev < trig_level && cur >= trig_level, evaluated on a sample_valid strobe. Both comparisons are unsigned 8-bit.
- States and transitions:
  - IDLE: entered on reset. Go to WAIT_TRIG when run = 1.
  - WAIT_TRIG: on the triggering sample_valid, write that sample at address 0, clear the decimation counter, set the address to 1, and go to CAPTURE.
  - CAPTURE: count each sample_valid. When the decimation counter reaches cstDecim-1, write at the current address, increment the address, and clear the counter. After the write at cstHorSize-1, pulse frame_done, load the holdoff counter, and go to HOLDOFF.
  - HOLDOFF: decrement the counter on each sample_valid. At zero, go to WAIT_TRIG if run = 1, otherwise IDLE.
- run = 0 in WAIT_TRIG returns to IDLE on the next cycle. run = 0 in CAPTURE or HOLDOFF takes effect only at the end of HOLDOFF.
- Address never exceeds cstHorSize-1. A frame always starts at 0; there is no wrap inside a frame.
- Reset mid-capture abandons the frame; the partial data in memory is left in place.
- trig_level is sampled on every compare, so changes take effect on the next strobe.

## Timing
- Reset values: enaTime = 0, weaTime = 0, addraTime = 0, dinaTime = 0, busy = 0, frame_done = 0. State = IDLE, all counters 0.
- Write latency: sample_valid in cycle N produces weaTime/enaTime/addraTime/dinaTime registered in cycle N+1. weaTime is high for exactly one cycle per write.
- Back-to-back sample_valid strobes produce back-to-back writes with consecutive addresses.
- addraTime and dinaTime hold their last written values between writes.
- IDLE to WAIT_TRIG: busy rises one cycle after run is sampled high.
- Trigger-to-first-write latency is 1 cycle.
- Frame duration is cstHorSize·cstDecim - (cstDecim-1) strobes after the trigger strobe.

## Configuration
- SCOPE_AUTOTRIG_EN defined:
  - A 16-bit timeout counter clears on entry to WAIT_TRIG and counts sample_valid strobes.
  - When it reaches cstAutoTmo-1, the current strobe is treated as a trigger regardless of level.
  - A real trigger on the same strobe is treated identically.
- SCOPE_AUTOTRIG_EN undefined: no timeout counter is present. WAIT_TRIG waits indefinitely for a real crossing.

## Test plan
- Reset and idle: assert rst for 3 cycles with run = 0, then apply 100 strobes. All outputs stay 0 and no write occurs.
- Basic frame: cstHorSize = 640, cstDecim = 1, trig_level = 128, run = 1. Apply a sawtooth sample_in from -2048 to +2047. The first write is at address 0 with data 128, one cycle after the 0 sample. Exactly 640 writes follow at addresses 0..639, and frame_done coincides with address 639.
- Decimation: cstDecim = 4, ramp input. Write k carries the trigger sample advanced by 4k steps, and the last write lands on strobe 2557 after the trigger.
- Back-to-back strobes: sample_valid held high for 640 cycles after the trigger gives 640 consecutive weaTime cycles. Then busy stays high through 4800 HOLDOFF strobes.
- run drop mid-capture: drop run at write 300. Capture completes to 639, HOLDOFF completes, then the state reaches IDLE and busy = 0. No new trigger is taken.
- Auto-trigger, with SCOPE_AUTOTRIG_EN defined: apply a constant sample_in of 0 with trig_level = 200. The forced trigger writes 128 at address 0 on strobe 9600. With the macro undefined, no write occurs after 20000 strobes.
